pwm_sync_buck_ctrl: RTL and testbench

Closed-loop PWM controller for a synchronous buck stage. It drives complementary high-side and low-side FET gates with a programmable period and fixed dead time. Duty is slew-limited towards the latest ADC sample, which is acquired by a periodic convert/busy/read sequencer. An over-voltage or ADC-timeout fault forces both gates off and latches until the block is disabled. It is the parametrised successor of the current single-mode PWM/ADC block and sits between the external parallel ADC and the gate drivers.

---
 rtl/pwm_sync_buck_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_pwm_sync_buck_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sync_buck_ctrl.sv
// Closed-loop PWM controller for a synchronous buck stage.
// A heartbeat-driven ADC sequencer acquires samples. Duty is slewed one
// step per switching period towards the clamped sample value. The gate FSM
// produces complementary HS/LS drive with dead time on both transitions.
//
// ADC sequencer
//   state  | meaning
//   IDLE   | waiting for a heartbeat request
//   CONV   | conv_start high for CONV_PULSE cycles
//   WAIT_H | waiting for busy to rise (timed out after BUSY_TIMEOUT)
//   WAIT_L | waiting for busy to fall (timed out after BUSY_TIMEOUT)
//   READ   | rd_cs low for RD_PULSE cycles, capture on the last one
//
// Gate FSM
//   state  | meaning
//   OFF    | both gates low (reset, disable or fault)
//   HS     | high-side on for duty_out cycles
//   DEAD1  | both low for DEAD_TIME cycles
//   LS     | low-side on for the rest of the period
//   DEAD2  | both low for DEAD_TIME cycles, then the next period starts
module pwm_sync_buck_ctrl #(
  parameter int PERIOD_W     = 8,
  parameter int ADC_W        = 8,
  parameter int DEAD_TIME    = 5,
  parameter int DUTY_MIN     = 3,
  parameter int CONV_PULSE   = 10,
  parameter int RD_PULSE     = 10,
  parameter int HEARTBEAT    = 1024,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                busy,
  input  logic [ADC_W-1:0]    adc_data,
  input  logic [PERIOD_W-1:0] pwm_period,
  input  logic [ADC_W-1:0]    ov_limit,
  output logic                conv_start,
  output logic                rd_cs,
  output logic                gate_hs,
  output logic                gate_ls,
  output logic                fault,
  output logic                sample_valid,
  output logic [PERIOD_W-1:0] duty_out
);

  localparam int HB_W     = $clog2(HEARTBEAT + 1);
  localparam int SEQ_MAX0 = (CONV_PULSE > RD_PULSE) ? CONV_PULSE : RD_PULSE;
  localparam int SEQ_MAX  = (SEQ_MAX0 > BUSY_TIMEOUT) ? SEQ_MAX0 : BUSY_TIMEOUT;
  localparam int SEQ_W    = $clog2(SEQ_MAX + 1);

  localparam logic [HB_W-1:0]     HB_LAST    = HB_W'(HEARTBEAT - 1);
  localparam logic [SEQ_W-1:0]    CONV_LD    = SEQ_W'(CONV_PULSE - 1);
  localparam logic [SEQ_W-1:0]    RD_LD      = SEQ_W'(RD_PULSE - 1);
  localparam logic [SEQ_W-1:0]    TO_LD      = SEQ_W'(BUSY_TIMEOUT - 1);
  localparam logic [PERIOD_W-1:0] DUTY_MIN_V = PERIOD_W'(DUTY_MIN);
  localparam logic [PERIOD_W-1:0] DEAD_LD    = PERIOD_W'(DEAD_TIME - 1);
  localparam logic [PERIOD_W:0]   DEAD_X2    = (PERIOD_W + 1)'(2 * DEAD_TIME);
  localparam logic [PERIOD_W:0]   DEAD_X2P1  = (PERIOD_W + 1)'(2 * DEAD_TIME + 1);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_WAIT_H, S_WAIT_L, S_READ} seq_t;
  typedef enum logic [2:0] {G_OFF, G_HS, G_DEAD1, G_LS, G_DEAD2} gate_t;

  logic              run;
  logic [HB_W-1:0]   hb_q, hb_d;
  logic              hb_req;

  seq_t              seq_q, seq_d;
  logic [SEQ_W-1:0]  scnt_q, scnt_d;
  logic [ADC_W-1:0]  sample_q, sample_d;
  logic              sv_q, sv_d;
  logic              capture, to_fault, ov_fault, fault_set;
  logic              fault_q, fault_d;

  gate_t             g_q, g_d;
  logic [PERIOD_W-1:0] gcnt_q, gcnt_d;
  logic [PERIOD_W-1:0] duty_q, duty_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic              hs_q, ls_q;
  logic              start;

  logic [PERIOD_W-1:0] target, dmax_eff, tgt_c, duty_slew, ls_ld;
  logic [PERIOD_W:0]   dmax_raw, ls_raw;

  // Reset and disable share one clear path.
  assign run = reset && enable;

  // Heartbeat counter: free-running while enabled, request at count 0.
  always_comb begin
    hb_d = (hb_q == HB_LAST) ? '0 : hb_q + 1'b1;
  end

  // Heartbeat register.
  always_ff @(posedge clk) begin
    if (!run) hb_q <= '0;
    else      hb_q <= hb_d;
  end

  assign hb_req = (hb_q == '0);

  // ADC sequencer next state; busy wins over a timeout on the same cycle.
  always_comb begin
    seq_d    = seq_q;
    scnt_d   = scnt_q;
    sample_d = sample_q;
    sv_d     = 1'b0;
    capture  = 1'b0;
    to_fault = 1'b0;
    case (seq_q)
      S_IDLE: begin
        if (hb_req) begin
          seq_d  = S_CONV;
          scnt_d = CONV_LD;
        end
      end
      S_CONV: begin
        if (scnt_q == '0) begin
          seq_d  = S_WAIT_H;
          scnt_d = TO_LD;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
      S_WAIT_H: begin
        if (busy) begin
          seq_d  = S_WAIT_L;
          scnt_d = TO_LD;
        end else if (scnt_q == '0) begin
          seq_d    = S_IDLE;
          to_fault = 1'b1;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
      S_WAIT_L: begin
        if (!busy) begin
          seq_d  = S_READ;
          scnt_d = RD_LD;
        end else if (scnt_q == '0) begin
          seq_d    = S_IDLE;
          to_fault = 1'b1;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
      S_READ: begin
        if (scnt_q == '0) begin
          seq_d    = S_IDLE;
          sample_d = adc_data;
          sv_d     = 1'b1;
          capture  = 1'b1;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
      default: seq_d = S_IDLE;
    endcase
  end

  assign ov_fault  = capture && (adc_data >= ov_limit);
  assign fault_set = to_fault || ov_fault;
  assign fault_d   = fault_q || fault_set;

  // Sequencer, sample and latched fault registers.
  always_ff @(posedge clk) begin
    if (!run) begin
      seq_q    <= S_IDLE;
      scnt_q   <= '0;
      sample_q <= '0;
      sv_q     <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      seq_q    <= seq_d;
      scnt_q   <= scnt_d;
      sample_q <= sample_d;
      sv_q     <= sv_d;
      fault_q  <= fault_d;
    end
  end

  // Sample scaled to the duty width: keep the MSBs, or zero-extend.
  if (ADC_W > PERIOD_W) begin : g_tgt_trunc
    assign target = sample_q[ADC_W-1 -: PERIOD_W];
  end else begin : g_tgt_ext
    assign target = PERIOD_W'(sample_q);
  end

  // Duty clamp and one-step slew, evaluated against the incoming period.
  always_comb begin
    dmax_raw = {1'b0, pwm_period} - DEAD_X2P1;
    if (dmax_raw[PERIOD_W] || (dmax_raw[PERIOD_W-1:0] < DUTY_MIN_V)) dmax_eff = DUTY_MIN_V;
    else                                                             dmax_eff = dmax_raw[PERIOD_W-1:0];
    if (target < DUTY_MIN_V)    tgt_c = DUTY_MIN_V;
    else if (target > dmax_eff) tgt_c = dmax_eff;
    else                        tgt_c = target;
    if (duty_q < tgt_c)      duty_slew = duty_q + 1'b1;
    else if (duty_q > tgt_c) duty_slew = duty_q - 1'b1;
    else                     duty_slew = duty_q;
    ls_raw = {1'b0, period_q} - {1'b0, duty_q} - DEAD_X2;
    if (ls_raw[PERIOD_W] || (ls_raw == '0)) ls_ld = '0;
    else                                    ls_ld = ls_raw[PERIOD_W-1:0] - 1'b1;
  end

  // Gate FSM next state; a fault (new or latched) overrides a period start.
  always_comb begin
    g_d      = g_q;
    gcnt_d   = gcnt_q;
    duty_d   = duty_q;
    period_d = period_q;
    start    = 1'b0;
    if (fault_q || fault_set) begin
      g_d = G_OFF;
    end else begin
      case (g_q)
        G_OFF: start = 1'b1;
        G_HS: begin
          if (gcnt_q == '0) begin
            g_d    = G_DEAD1;
            gcnt_d = DEAD_LD;
          end else begin
            gcnt_d = gcnt_q - 1'b1;
          end
        end
        G_DEAD1: begin
          if (gcnt_q == '0) begin
            g_d    = G_LS;
            gcnt_d = ls_ld;
          end else begin
            gcnt_d = gcnt_q - 1'b1;
          end
        end
        G_LS: begin
          if (gcnt_q == '0) begin
            g_d    = G_DEAD2;
            gcnt_d = DEAD_LD;
          end else begin
            gcnt_d = gcnt_q - 1'b1;
          end
        end
        G_DEAD2: begin
          if (gcnt_q == '0) start = 1'b1;
          else              gcnt_d = gcnt_q - 1'b1;
        end
        default: g_d = G_OFF;
      endcase
      if (start) begin
        g_d      = G_HS;
        period_d = pwm_period;
        duty_d   = duty_slew;
        gcnt_d   = duty_slew - 1'b1;
      end
    end
  end

  // Gate FSM state, applied duty, latched period and registered gate drives.
  always_ff @(posedge clk) begin
    if (!run) begin
      g_q      <= G_OFF;
      gcnt_q   <= '0;
      duty_q   <= DUTY_MIN_V;
      period_q <= '0;
      hs_q     <= 1'b0;
      ls_q     <= 1'b0;
    end else begin
      g_q      <= g_d;
      gcnt_q   <= gcnt_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      hs_q     <= (g_d == G_HS);
      ls_q     <= (g_d == G_LS);
    end
  end

  assign conv_start   = (seq_q == S_CONV);
  assign rd_cs        = (seq_q != S_READ);
  assign gate_hs      = hs_q;
  assign gate_ls      = ls_q;
  assign fault        = fault_q;
  assign sample_valid = sv_q;
  assign duty_out     = duty_q;

endmodule

// File: tb/tb_pwm_sync_buck_ctrl.sv
// Bench for pwm_sync_buck_ctrl: stimulus queues expected events, a monitor
// measures periods, ADC handshakes and fault onsets and compares them.
`timescale 1ns/1ps
module tb_pwm_sync_buck_ctrl;

  logic       clk = 1'b0;
  logic       reset, enable, busy;
  logic [7:0] adc_data, pwm_period, ov_limit;
  logic       conv_start, rd_cs, gate_hs, gate_ls, fault, sample_valid;
  logic [7:0] duty_out;

  always #5 clk = ~clk;

  pwm_sync_buck_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .busy(busy),
    .adc_data(adc_data), .pwm_period(pwm_period), .ov_limit(ov_limit),
    .conv_start(conv_start), .rd_cs(rd_cs), .gate_hs(gate_hs), .gate_ls(gate_ls),
    .fault(fault), .sample_valid(sample_valid), .duty_out(duty_out)
  );

  typedef struct { int duty; int hs; int d1; int ls; int d2; } per_t;
  typedef struct { int conv; int rd; } adc_t;
  typedef struct { int ofs; int prev_hs; } flt_t;

  per_t q_per[$];
  adc_t q_adc[$];
  flt_t q_flt[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_cyc = 0;
  bit busy_stuck = 1'b0;
  bit gate_in_fault = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ADC model: busy rises right after conv_start falls, high for 20 cycles.
  initial begin : busy_model
    int  bcnt;
    logic cprev;
    bcnt = 0;
    cprev = 1'b0;
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (cprev && !conv_start && !busy_stuck) bcnt = 20;
      if (bcnt > 0) begin
        busy = 1'b1;
        bcnt--;
      end else begin
        busy = 1'b0;
      end
      cprev = conv_start;
    end
  end

  // Monitor state
  int   m_hs, m_d1, m_ls, m_d2, m_duty, m_conv, m_rd, m_ofs;
  bit   in_per = 1'b0;
  int   prev_hs = 0;
  logic prev_fault = 1'b0, prev_sv = 1'b0, prev_conv = 1'b0, prev_rd = 1'b1;
  per_t pe;
  adc_t ae;
  flt_t fe;

  initial begin : monitor
    forever begin
      @(negedge clk);
      checks++;
      assert (!(gate_hs && gate_ls)) else begin
        errors++;
        $display("FAIL overlap: gate_hs=%0b gate_ls=%0b at cycle %0d, required not both 1", gate_hs, gate_ls, cyc);
      end
      if (fault && (gate_hs || gate_ls)) gate_in_fault = 1'b1;

      if (conv_start) m_conv = prev_conv ? m_conv + 1 : 1;
      if (!rd_cs)     m_rd   = prev_rd   ? 1 : m_rd + 1;
      if (sample_valid) begin
        checks++;
        if (prev_sv) begin
          errors++;
          $display("FAIL sv_pulse: sample_valid high 2 cycles, required 1");
        end
        if (!prev_sv && q_adc.size() > 0) begin
          ae = q_adc.pop_front();
          checks++;
          if (m_conv != ae.conv || m_rd != ae.rd) begin
            errors++;
            $display("FAIL adc_seq: conv=%0d rd=%0d, required conv=%0d rd=%0d", m_conv, m_rd, ae.conv, ae.rd);
          end
        end
      end

      if (fault && !prev_fault && q_flt.size() > 0) begin
        fe = q_flt.pop_front();
        m_ofs = cyc - en_cyc - 1;
        checks++;
        if (m_ofs != fe.ofs || prev_hs != fe.prev_hs || gate_hs || gate_ls) begin
          errors++;
          $display("FAIL fault_onset: cycle=%0d prev_hs=%0d hs=%0b ls=%0b, required cycle=%0d prev_hs=%0d hs=0 ls=0",
                   m_ofs, prev_hs, gate_hs, gate_ls, fe.ofs, fe.prev_hs);
        end
      end

      if (!reset || !enable || fault) begin
        in_per = 1'b0;
      end else begin
        if (gate_hs && prev_hs == 0) begin
          if (in_per && q_per.size() > 0) begin
            pe = q_per.pop_front();
            checks++;
            if (m_duty != pe.duty || m_hs != pe.hs || m_d1 != pe.d1 || m_ls != pe.ls || m_d2 != pe.d2) begin
              errors++;
              $display("FAIL period: duty=%0d hs=%0d d1=%0d ls=%0d d2=%0d, required duty=%0d hs=%0d d1=%0d ls=%0d d2=%0d",
                       m_duty, m_hs, m_d1, m_ls, m_d2, pe.duty, pe.hs, pe.d1, pe.ls, pe.d2);
            end
          end
          in_per = 1'b1;
          m_hs = 0; m_d1 = 0; m_ls = 0; m_d2 = 0;
          m_duty = int'(duty_out);
        end
        if (in_per) begin
          if (gate_hs)      m_hs++;
          else if (gate_ls) m_ls++;
          else if (m_ls == 0) m_d1++;
          else              m_d2++;
        end
      end
      prev_hs    = int'(gate_hs);
      prev_fault = fault;
      prev_sv    = sample_valid;
      prev_conv  = conv_start;
      prev_rd    = rd_cs;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    logic [13:0] act, exp;
    act = {conv_start, rd_cs, gate_hs, gate_ls, fault, sample_valid, duty_out};
    exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: outputs=%h, required %h", name, act, exp);
    end
  endtask

  task automatic push_per(input int p, input int d);
    per_t e;
    e.duty = d; e.hs = d; e.d1 = 5; e.ls = p - d - 10; e.d2 = 5;
    q_per.push_back(e);
  endtask

  task automatic push_adc();
    adc_t e;
    e.conv = 10; e.rd = 10;
    q_adc.push_back(e);
  endtask

  task automatic push_flt(input int ofs, input int phs);
    flt_t e;
    e.ofs = ofs; e.prev_hs = phs;
    q_flt.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((q_per.size() + q_adc.size() + q_flt.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, q_per.size() + q_adc.size() + q_flt.size(), 0);
  endtask

  task automatic go();
    @(negedge clk);
    enable = 1'b1;
    en_cyc = cyc;
  endtask

  task automatic stop();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin : stim
    int n;
    reset = 1'b0; enable = 1'b0;
    adc_data = 8'h00; pwm_period = 8'd100; ov_limit = 8'hFF;
    repeat (5) @(negedge clk);
    check_idle_outputs("reset_state");
    reset = 1'b1;
    @(negedge clk);

    // Sample 0: duty held at the minimum, 3/5/87/5
    for (int i = 0; i < 4; i++) push_per(100, 3);
    push_adc();
    go();
    drain("drain_min_duty", 1000);
    stop();

    // Sample 0x40: ramp 3 -> 64 one step per period, then hold
    adc_data = 8'h40;
    for (int d = 3; d <= 64; d++) push_per(100, d);
    push_per(100, 64);
    push_per(100, 64);
    push_adc();
    go();
    drain("drain_ramp", 8000);
    check("duty_hold_64", int'(duty_out), 64);
    stop();
    check_idle_outputs("disable_state");

    // Sample 0xF0: saturate at 100-10-1 = 89, LS shrinks to 1 cycle
    adc_data = 8'hF0;
    for (int d = 3; d <= 89; d++) push_per(100, d);
    for (int i = 0; i < 3; i++) push_per(100, 89);
    go();
    drain("drain_saturate", 10000);
    check("duty_sat_89", int'(duty_out), 89);
    stop();

    // Over-voltage capture while HS is on (period 39: capture lands in HS)
    pwm_period = 8'd39; ov_limit = 8'h80; adc_data = 8'h90;
    push_per(39, 3);
    push_flt(41, 1);
    go();
    drain("drain_ov_fault", 300);
    gate_in_fault = 1'b0;
    repeat (100) @(negedge clk);
    check("gates_off_in_fault", int'(gate_in_fault), 0);
    check("fault_latched", int'(fault), 1);
    ov_limit = 8'hFF; adc_data = 8'h00;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("fault_cleared", int'(fault), 0);
    push_per(39, 3);
    push_per(39, 3);
    go();
    drain("drain_restart", 300);
    stop();

    // Busy never rises: timeout 255 cycles after WAIT_H entry (cycle 10)
    pwm_period = 8'd100; busy_stuck = 1'b1;
    push_per(100, 3);
    push_per(100, 3);
    push_flt(265, 0);
    go();
    drain("drain_timeout", 600);
    n = 0;
    while (!conv_start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("next_conv_cycle", cyc - en_cyc - 1, 1024);
    check("fault_during_resample", int'(fault), 1);
    busy_stuck = 1'b0;
    stop();

    // One-cycle reset pulse during LS
    go();
    n = 0;
    while (!gate_ls && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reached_ls", int'(gate_ls), 1);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_in_ls");
    reset = 1'b1;
    push_per(100, 3);
    push_per(100, 3);
    drain("drain_after_reset", 500);
    stop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
